// File: rtl/bcd_to_bin_if.sv
// Handshake/data bundle between a BCD source and the bcd_to_bin converter.
// BCD2BIN_SIGN_EN adds the neg request bit.
interface bcd_to_bin_if #(
  parameter int DWIDTH = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
`ifdef BCD2BIN_SIGN_EN
  logic                  neg;
`endif
  logic                  busy;
  logic                  valid;
  logic [DWIDTH-1:0]     dout;
  logic                  ovf;
  logic                  err;

`ifdef BCD2BIN_SIGN_EN
  modport master (output start, bcd_in, neg, input busy, valid, dout, ovf, err);
  modport slave  (input start, bcd_in, neg, output busy, valid, dout, ovf, err);
`else
  modport master (output start, bcd_in, input busy, valid, dout, ovf, err);
  modport slave  (input start, bcd_in, output busy, valid, dout, ovf, err);
`endif
endinterface

// File: rtl/bcd_to_bin.sv
// Sequential reverse double-dabble BCD-to-binary converter, one shift per clock.
// Optional signed result (neg request) when BCD2BIN_SIGN_EN is defined.
//
//   state  | meaning
//   IDLE   | waiting for start, bcd_in checked for digits > 9
//   CONV   | shifting {bcd, bin} right, BW iterations
//   DONE   | valid pulse, results already latched
module bcd_to_bin #(
  parameter int DWIDTH = 8,
  parameter int DIGITS = 3
) (
  input  logic        clk,
  input  logic        rst,
  bcd_to_bin_if.slave bus
);
  localparam int BW = $clog2(10**DIGITS);
  localparam int SW = 4*DIGITS + BW;
  localparam int CW = $clog2(BW+1);
  localparam int MW = ((BW > DWIDTH) ? BW : DWIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     sr_q, sr_d;
  logic [DWIDTH-1:0] dout_q, dout_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;
`ifdef BCD2BIN_SIGN_EN
  logic              neg_q, neg_d;
  logic [MW-1:0]     lim;
  logic [MW-1:0]     neg_mag;
`endif

  logic              bad_digit;
  logic [SW-1:0]     shifted;
  logic [3:0]        nib;
  logic [MW-1:0]     mag;
  logic [DWIDTH-1:0] res_dout;
  logic              res_ovf;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // Correction is per nibble, no borrow propagates between digits.
  always_comb begin
    shifted = sr_q >> 1;
    nib     = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      nib = shifted[BW+4*i +: 4];
      if (nib >= 4'd8) shifted[BW+4*i +: 4] = nib - 4'd3;
    end
  end

  always_comb begin
    mag = MW'(shifted[BW-1:0]);
`ifdef BCD2BIN_SIGN_EN
    lim      = MW'(1) << (DWIDTH-1);
    neg_mag  = -mag;
    res_dout = neg_q ? neg_mag[DWIDTH-1:0] : mag[DWIDTH-1:0];
    res_ovf  = neg_q ? (mag > lim) : (mag >= lim);
`else
    res_dout = mag[DWIDTH-1:0];
    res_ovf  = |(mag >> DWIDTH);
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    dout_d  = dout_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
`ifdef BCD2BIN_SIGN_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bad_digit) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            dout_d  = '0;
            ovf_d   = 1'b0;
          end else begin
            state_d = S_CONV;
            sr_d    = {bus.bcd_in, {BW{1'b0}}};
            cnt_d   = '0;
`ifdef BCD2BIN_SIGN_EN
            neg_d   = bus.neg;
`endif
          end
        end
      end
      S_CONV: begin
        sr_d  = shifted;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(BW-1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
          dout_d  = res_dout;
          ovf_d   = res_ovf;
          err_d   = 1'b0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef BCD2BIN_SIGN_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
`ifdef BCD2BIN_SIGN_EN
      neg_q   <= neg_d;
`endif
    end
  end

  assign bus.busy  = (state_q == S_CONV);
  assign bus.valid = (state_q == S_DONE);
  assign bus.dout  = dout_q;
  assign bus.ovf   = ovf_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed-vector bench for bcd_to_bin (DWIDTH=8, DIGITS=3).
// Signed vectors are used when BCD2BIN_SIGN_EN is defined.
module tb_bcd_to_bin;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_mis = 0;

`ifdef BCD2BIN_SIGN_EN
  localparam logic OVF_200 = 1'b1;
`else
  localparam logic OVF_200 = 1'b0;
`endif

  bcd_to_bin_if #(.DWIDTH(8), .DIGITS(3)) ifc ();

  bcd_to_bin #(.DWIDTH(8), .DIGITS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_start(input logic [11:0] bcd, input logic n);
    @(negedge clk);
    ifc.start  = 1'b1;
    ifc.bcd_in = bcd;
`ifdef BCD2BIN_SIGN_EN
    ifc.neg    = n;
`else
    if (n) ifc.start = 1'b1;
`endif
    @(posedge clk);
    #1;
    ifc.start  = 1'b0;
    ifc.bcd_in = 12'h0F0;
`ifdef BCD2BIN_SIGN_EN
    ifc.neg    = ~n;
`endif
  endtask

  task automatic convert(input string tag, input logic [11:0] bcd, input logic n,
                         input logic [7:0] exp_d, input logic exp_o, input logic exp_e);
    int   lat;
    logic busy_seen;
    drive_start(bcd, n);
    lat       = 1;
    busy_seen = ifc.busy;
    while (!ifc.valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      busy_seen |= ifc.busy;
    end
    check({tag, ".lat"},  lat,       exp_e ? 1 : 11);
    check({tag, ".busy"}, busy_seen, !exp_e);
    check({tag, ".dout"}, ifc.dout,  exp_d);
    check({tag, ".ovf"},  ifc.ovf,   exp_o);
    check({tag, ".err"},  ifc.err,   exp_e);
    @(posedge clk);
    #1;
    check({tag, ".vdrop"}, ifc.valid, 1'b0);
    check({tag, ".hold"},  ifc.dout,  exp_d);
  endtask

  initial begin
    int       nval;
    logic [7:0] cap;
    rst        = 1'b1;
    ifc.start  = 1'b0;
    ifc.bcd_in = '0;
`ifdef BCD2BIN_SIGN_EN
    ifc.neg    = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy",  ifc.busy,  1'b0);
    check("rst.valid", ifc.valid, 1'b0);
    check("rst.dout",  ifc.dout,  8'h00);
    check("rst.ovf",   ifc.ovf,   1'b0);
    check("rst.err",   ifc.err,   1'b0);
    @(negedge clk);
    rst = 1'b0;

`ifdef BCD2BIN_SIGN_EN
    convert("s128n", 12'h128, 1'b1, 8'h80, 1'b0, 1'b0);
    convert("s128p", 12'h128, 1'b0, 8'h80, 1'b1, 1'b0);
    convert("s001n", 12'h001, 1'b1, 8'hFF, 1'b0, 1'b0);
    convert("s000n", 12'h000, 1'b1, 8'h00, 1'b0, 1'b0);
    convert("s127p", 12'h127, 1'b0, 8'h7F, 1'b0, 1'b0);
    convert("s129n", 12'h129, 1'b1, 8'h7F, 1'b1, 1'b0);
    convert("s255n", 12'h255, 1'b1, 8'h01, 1'b1, 1'b0);
    convert("s999p", 12'h999, 1'b0, 8'hE7, 1'b1, 1'b0);
`else
    convert("u255", 12'h255, 1'b0, 8'hFF, 1'b0, 1'b0);
    convert("u256", 12'h256, 1'b0, 8'h00, 1'b1, 1'b0);
    convert("u000", 12'h000, 1'b0, 8'h00, 1'b0, 1'b0);
    convert("u100", 12'h100, 1'b0, 8'h64, 1'b0, 1'b0);
    convert("u087", 12'h087, 1'b0, 8'h57, 1'b0, 1'b0);
    convert("u999", 12'h999, 1'b0, 8'hE7, 1'b1, 1'b0);
`endif
    convert("bad09A", 12'h09A, 1'b0, 8'h00, 1'b0, 1'b1);
    convert("badA00", 12'hA00, 1'b0, 8'h00, 1'b0, 1'b1);

    // second start lands mid-conversion and must be dropped
    drive_start(12'h123, 1'b0);
    repeat (3) @(posedge clk);
    drive_start(12'h045, 1'b0);
    nval = 0;
    cap  = 8'h00;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (ifc.valid) begin
        nval++;
        cap = ifc.dout;
      end
    end
    check("busy2.nval", nval, 1);
    check("busy2.dout", cap,  8'd123);

    convert("pre999", 12'h999, 1'b0, 8'hE7, 1'b1, 1'b0);
    drive_start(12'h200, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mrst.busy",  ifc.busy,  1'b0);
    check("mrst.valid", ifc.valid, 1'b0);
    check("mrst.dout",  ifc.dout,  8'h00);
    check("mrst.ovf",   ifc.ovf,   1'b0);
    check("mrst.err",   ifc.err,   1'b0);
    @(negedge clk);
    rst  = 1'b0;
    nval = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (ifc.valid) nval++;
    end
    check("mrst.novalid", nval, 0);
    convert("post200", 12'h200, 1'b0, 8'hC8, OVF_200, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
